led_array_ctrl: RTL and testbench

//  Parametrised multi-channel LED driver; successor to the single-LED blink unit.
//  Per-channel mode (OFF/ON/BLINK/PWM) is set over a valid/ready config port.

---
 rtl/led_array_ctrl_pkg.sv | 30 +++
 rtl/led_array_ctrl_if.sv | 36 +++
 rtl/led_array_ctrl_channel.sv | 70 +++++++
 rtl/led_array_ctrl.sv | 113 +++++++++++
 tb/tb_led_array_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_array_ctrl_pkg.sv
// ============================================================================
//  Module      : led_pkg
//  Description : Shared types and elaboration helpers for the LED array
//                controller (channel mode encoding, prescaler and width math).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_PWM   = 2'd3
    } led_mode_t;

    // Number of clk cycles per blink time-base tick.
    function automatic int calc_prescale(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Channel-select width; a single-channel array still gets a 1-bit select.
    function automatic int ch_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_array_ctrl_if.sv
// ============================================================================
//  Module      : led_array_ctrl_if
//  Description : Valid/ready configuration port of the LED array controller.
//                master = config source, slave = controller.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface led_array_ctrl_if #(
    parameter int N_CH     = 4,
    parameter int PWM_BITS = 8
);
    import led_pkg::*;

    localparam int CH_W = ch_width(N_CH);

    logic                cfg_valid;
    logic                cfg_ready;
    logic [CH_W-1:0]     cfg_ch;
    led_mode_t           cfg_mode;
    logic [PWM_BITS-1:0] cfg_duty;
    logic                cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_duty,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_duty,
        output cfg_ready, cfg_err
    );

endinterface

`default_nettype wire

// File: rtl/led_array_ctrl_channel.sv
// ============================================================================
//  Module      : led_channel
//  Description : One LED channel: mode register, shadow/active PWM duty and
//                the registered LED output.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module led_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic                on_i,
    input  wire logic                wr_en_i,
    input  wire led_mode_t           mode_i,
    input  wire logic [PWM_BITS-1:0] duty_i,
    input  wire logic [PWM_BITS-1:0] pwm_cnt_i,
    input  wire logic                pwm_wrap_i,
    input  wire logic                blink_phase_i,
    output logic                     led_o
);

    led_mode_t           mode_q;
    logic [PWM_BITS-1:0] shadow_q;
    logic [PWM_BITS-1:0] duty_q;
    logic                led_q;
    logic                led_d;

    // Next LED level from the current mode; global enable low forces dark.
    always_comb begin
        led_d = 1'b0;
        if (on_i) begin
            case (mode_q)
                LED_OFF:   led_d = 1'b0;
                LED_ON:    led_d = 1'b1;
                LED_BLINK: led_d = blink_phase_i;
                LED_PWM:   led_d = (pwm_cnt_i < duty_q);
                default:   led_d = 1'b0;
            endcase
        end
    end

    // Config capture; active duty only changes at a PWM period boundary so a
    // running period is never cut short or stretched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q   <= LED_OFF;
            shadow_q <= '0;
            duty_q   <= '0;
            led_q    <= 1'b0;
        end else begin
            if (wr_en_i) begin
                mode_q   <= mode_i;
                shadow_q <= duty_i;
            end
            if (pwm_wrap_i) begin
                duty_q <= wr_en_i ? duty_i : shadow_q;
            end
            led_q <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

`default_nettype wire

// File: rtl/led_array_ctrl.sv
// ============================================================================
//  Module      : led_array_ctrl
//  Description : Multi-channel LED driver. Shared prescaler/blink phase and
//                shared PWM counter feed one led_channel per LED.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module led_array_ctrl
    import led_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CLK_HZ      = 100_000_000,
    parameter int TICK_HZ     = 1_000,
    parameter int BLINK_TICKS = 500,
    parameter int PWM_BITS    = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         on,
    led_array_ctrl_if.slave   cfg,
    output logic              tick,
    output logic [N_CH-1:0]   led
);

    localparam int PRESCALE = calc_prescale(CLK_HZ, TICK_HZ);
    localparam int PRE_W    = $clog2(PRESCALE);
    localparam int BLK_W    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [PRE_W-1:0] c_PRE_MAX = PRE_W'(PRESCALE - 1);
    localparam logic [BLK_W-1:0] c_BLK_MAX = BLK_W'(BLINK_TICKS - 1);

    logic [PRE_W-1:0]    presc_q,       presc_d;
    logic [BLK_W-1:0]    blink_cnt_q,   blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [PWM_BITS-1:0] pwm_cnt_q,     pwm_cnt_d;
    logic                ready_q;
    logic                err_q;

    logic                tick_w;
    logic                pwm_wrap_w;
    logic                accept_w;
    logic                ch_ok_w;
    logic [N_CH-1:0]     wr_en_w;

    assign tick_w     = (presc_q == c_PRE_MAX);
    assign pwm_wrap_w = &pwm_cnt_q;
    assign accept_w   = cfg.cfg_valid & ready_q;
    assign ch_ok_w    = (int'(cfg.cfg_ch) < N_CH);

    // Next values of the shared time bases.
    always_comb begin
        presc_d       = tick_w ? '0 : presc_q + 1'b1;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (tick_w) begin
            if (blink_cnt_q == c_BLK_MAX) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + 1'b1;
            end
        end
        pwm_cnt_d = pwm_cnt_q + 1'b1;
    end

    // Shared counters, config-ready and out-of-range error pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q       <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            pwm_cnt_q     <= '0;
            ready_q       <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            pwm_cnt_q     <= pwm_cnt_d;
            ready_q       <= 1'b1;
            err_q         <= accept_w & ~ch_ok_w;
        end
    end

    assign tick          = tick_w;
    assign cfg.cfg_ready = ready_q;
    assign cfg.cfg_err   = err_q;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            assign wr_en_w[i] = accept_w & ch_ok_w & (int'(cfg.cfg_ch) == i);

            led_channel #(
                .PWM_BITS (PWM_BITS)
            ) u_channel (
                .clk           (clk),
                .reset         (reset),
                .on_i          (on),
                .wr_en_i       (wr_en_w[i]),
                .mode_i        (cfg.cfg_mode),
                .duty_i        (cfg.cfg_duty),
                .pwm_cnt_i     (pwm_cnt_q),
                .pwm_wrap_i    (pwm_wrap_w),
                .blink_phase_i (blink_phase_q),
                .led_o         (led[i])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_led_array_ctrl.sv
// ============================================================================
//  Module      : tb_led_array_ctrl
//  Description : Self-checking bench for led_array_ctrl with a cycle-level
//                reference model derived from elapsed-cycle arithmetic.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_led_array_ctrl;
    import led_pkg::*;

    // Five channels so a 3-bit select can address out-of-range channels 5..7.
    localparam int N_CH        = 5;
    localparam int CLK_HZ      = 1000;
    localparam int TICK_HZ     = 100;
    localparam int BLINK_TICKS = 3;
    localparam int PWM_BITS    = 4;
    localparam int PRE         = CLK_HZ / TICK_HZ;     // 10
    localparam int PWM_LEN     = 1 << PWM_BITS;        // 16
    localparam int HALF_BLINK  = PRE * BLINK_TICKS;    // 30

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            on = 1'b1;
    logic            tick;
    logic [N_CH-1:0] led;

    led_array_ctrl_if #(.N_CH(N_CH), .PWM_BITS(PWM_BITS)) cfg_if ();

    led_array_ctrl #(
        .N_CH        (N_CH),
        .CLK_HZ      (CLK_HZ),
        .TICK_HZ     (TICK_HZ),
        .BLINK_TICKS (BLINK_TICKS),
        .PWM_BITS    (PWM_BITS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .on    (on),
        .cfg   (cfg_if.slave),
        .tick  (tick),
        .led   (led)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // n = clock edges since reset release; every shared counter is a
    // function of n alone.
    int unsigned     n = 0;
    bit              ready_m = 1'b0;
    bit              exp_err = 1'b0;
    logic [N_CH-1:0] exp_led = '0;
    led_mode_t       m_mode   [N_CH];
    int              m_shadow [N_CH];
    int              m_act    [N_CH];

    always @(posedge clk or negedge reset) begin : p_model
        int  pwm;
        bit  ph;
        bit  acc;
        int  ch;
        if (!reset) begin
            n       = 0;
            ready_m = 1'b0;
            exp_err = 1'b0;
            exp_led = '0;
            for (int i = 0; i < N_CH; i++) begin
                m_mode[i]   = LED_OFF;
                m_shadow[i] = 0;
                m_act[i]    = 0;
            end
        end else begin
            pwm = int'(n % PWM_LEN);
            ph  = ((n / HALF_BLINK) % 2) == 1;
            for (int i = 0; i < N_CH; i++) begin
                exp_led[i] = on && ((m_mode[i] == LED_ON) ||
                                    (m_mode[i] == LED_BLINK && ph) ||
                                    (m_mode[i] == LED_PWM && pwm < m_act[i]));
            end
            acc     = cfg_if.cfg_valid && ready_m;
            ch      = int'(cfg_if.cfg_ch);
            exp_err = acc && (ch >= N_CH);
            if (acc && ch < N_CH) begin
                m_mode[ch]   = cfg_if.cfg_mode;
                m_shadow[ch] = int'(cfg_if.cfg_duty);
            end
            if (pwm == PWM_LEN - 1) begin
                for (int i = 0; i < N_CH; i++) m_act[i] = m_shadow[i];
            end
            ready_m = 1'b1;
            n++;
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("led",   32'(led), 32'(exp_led));
        chk("tick",  32'(tick), 32'((n % PRE) == PRE - 1));
        chk("ready", 32'(cfg_if.cfg_ready), 32'(ready_m));
        chk("err",   32'(cfg_if.cfg_err), 32'(exp_err));
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- stimulus helpers ----------------
    task automatic write_cfg(input int ch, input int mode, input int duty);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 3'(ch);
        cfg_if.cfg_mode  = led_mode_t'(mode);
        cfg_if.cfg_duty  = 4'(duty);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic count_high(input int ch, output int cnt);
        cnt = 0;
        for (int k = 0; k < PWM_LEN; k++) begin
            @(negedge clk);
            if (led[ch]) cnt++;
        end
    endtask

    task automatic wait_toggle(input int ch, output int at_cyc);
        logic prev;
        bit   seen;
        prev = led[ch];
        seen = 1'b0;
        at_cyc = -1;
        for (int k = 0; k < 4 * HALF_BLINK && !seen; k++) begin
            @(negedge clk);
            if (led[ch] !== prev) begin
                seen   = 1'b1;
                at_cyc = cyc;
            end
        end
        chk("blink_toggle_seen", 32'(seen), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin : p_main
        int k;
        int cnt;
        int t0, t1, t2;

        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_mode  = LED_ON;
        cfg_if.cfg_duty  = '0;

        // Reset held with a pending request: nothing may be accepted.
        repeat (3) @(negedge clk);
        chk("rst_led",   32'(led), 32'd0);
        chk("rst_ready", 32'(cfg_if.cfg_ready), 32'd0);
        chk("rst_tick",  32'(tick), 32'd0);
        reset            = 1'b1;
        cfg_if.cfg_valid = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_release", 32'(cfg_if.cfg_ready), 32'd1);

        // Tick is high during the PRE-th cycle, i.e. after the (PRE-1)-th edge.
        k = 1;
        while (!tick && k < 3 * PRE) begin
            @(posedge clk); #1;
            k++;
        end
        chk("first_tick_edge", 32'(k), 32'(PRE - 1));

        // ON: visible two edges after valid is first sampled.
        write_cfg(2, LED_ON, 0);
        chk("on_not_yet", 32'(led[2]), 32'd0);
        @(negedge clk);
        chk("on_led2", 32'(led[2]), 32'd1);

        on = 1'b0;
        @(negedge clk);
        chk("global_off", 32'(led), 32'd0);
        on = 1'b1;
        @(negedge clk);
        chk("global_on_led2", 32'(led[2]), 32'd1);

        // BLINK: half-period of PRE*BLINK_TICKS cycles; second channel aligned.
        write_cfg(0, LED_BLINK, 0);
        wait_toggle(0, t0);
        wait_toggle(0, t1);
        wait_toggle(0, t2);
        chk("blink_half_period_a", 32'(t1 - t0), 32'(HALF_BLINK));
        chk("blink_half_period_b", 32'(t2 - t1), 32'(HALF_BLINK));
        write_cfg(3, LED_BLINK, 7);
        repeat (5) @(negedge clk);
        for (int j = 0; j < 2 * HALF_BLINK; j++) begin
            @(negedge clk);
            if (led[3] !== led[0]) chk("blink_aligned", 32'(led[3]), 32'(led[0]));
        end
        chk("blink_aligned_end", 32'(led[3]), 32'(led[0]));

        // PWM duty sweep: any 16-cycle window holds exactly 'duty' high cycles.
        write_cfg(1, LED_PWM, 5);
        repeat (2 * PWM_LEN) @(negedge clk);
        count_high(1, cnt);
        chk("pwm_duty5", 32'(cnt), 32'd5);
        write_cfg(1, LED_PWM, 0);
        repeat (2 * PWM_LEN) @(negedge clk);
        count_high(1, cnt);
        chk("pwm_duty0", 32'(cnt), 32'd0);
        write_cfg(1, LED_PWM, 15);
        repeat (2 * PWM_LEN) @(negedge clk);
        count_high(1, cnt);
        chk("pwm_duty15", 32'(cnt), 32'd15);

        // Mid-period duty change 5 -> 12; the model checks each cycle.
        write_cfg(1, LED_PWM, 5);
        repeat (2 * PWM_LEN + 3) @(negedge clk);
        write_cfg(1, LED_PWM, 12);
        repeat (2 * PWM_LEN) @(negedge clk);
        count_high(1, cnt);
        chk("pwm_duty12", 32'(cnt), 32'd12);

        // Out-of-range channel: error pulse only.
        write_cfg(5, LED_OFF, 0);
        chk("bad_ch_err", 32'(cfg_if.cfg_err), 32'd1);
        chk("bad_ch_led2", 32'(led[2]), 32'd1);
        @(negedge clk);
        chk("bad_ch_err_clear", 32'(cfg_if.cfg_err), 32'd0);
        chk("bad_ch_led2_kept", 32'(led[2]), 32'd1);

        // Asynchronous reset mid-PWM.
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_led",   32'(led), 32'd0);
        chk("async_rst_ready", 32'(cfg_if.cfg_ready), 32'd0);
        chk("async_rst_tick",  32'(tick), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic, including out-of-range channels and enable flips.
        for (int j = 0; j < 1500; j++) begin
            @(negedge clk);
            cfg_if.cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_if.cfg_ch    = 3'($urandom_range(0, 7));
            cfg_if.cfg_mode  = led_mode_t'($urandom_range(0, 3));
            cfg_if.cfg_duty  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) on = ~on;
        end
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
